// File: rtl/mips_pkg.sv
// Encodings shared by the MIPS stage sequencer and the datapath-side stage responder.
// The sequencer must use these exact stage codes and opcodes.
package mips_pkg;

    localparam logic [2:0] STAGE_FETCH     = 3'd0;
    localparam logic [2:0] STAGE_DECODE    = 3'd1;
    localparam logic [2:0] STAGE_EXECUTE   = 3'd2;
    localparam logic [2:0] STAGE_MEMORY    = 3'd3;
    localparam logic [2:0] STAGE_WRITEBACK = 3'd4;
    localparam logic [2:0] STAGE_EXTRA     = 3'd6;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_MEM_WAIT,
        ST_ACK
    } rsp_state_t;

    // Codes 5 and 7 are the only holes in the stage map.
    function automatic logic is_legal_stage(input logic [2:0] code);
        return (code <= STAGE_WRITEBACK) || (code == STAGE_EXTRA);
    endfunction

endpackage

// File: rtl/mips_stage_responder_if.sv
// Command/acknowledge and datapath-strobe bundle between the stage sequencer (master)
// and the stage responder (slave); mem_ready comes from memory alongside the commands.
interface mips_stage_responder_if #(
    parameter int CNT_W = 32
);
    logic [2:0]       stage_code;
    logic             stage_valid;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             stage_ack;
    logic             stage_err;
    logic             busy;
    logic             ir_we;
    logic             pc_we;
    logic             reg_rd;
    logic             alu_en;
    logic             mem_req;
    logic             mem_we;
    logic             reg_we;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output stage_code, stage_valid, opcode, mem_ready,
        input  stage_ack, stage_err, busy, ir_we, pc_we, reg_rd, alu_en,
               mem_req, mem_we, reg_we, retired_count
    );

    modport slave (
        input  stage_code, stage_valid, opcode, mem_ready,
        output stage_ack, stage_err, busy, ir_we, pc_we, reg_rd, alu_en,
               mem_req, mem_we, reg_we, retired_count
    );
endinterface

// File: rtl/mips_mem_handshake.sv
// Wait-cycle counter and ready/timeout decision while the responder sits in MEM_WAIT.
// Count is 0 on the first wait cycle; ready on the final cycle beats the timeout.
module mips_mem_handshake #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_waiting,
    input  logic i_mem_ready,
    output logic o_done,
    output logic o_timed_out
);
    localparam int              TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] r_wait_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (i_waiting) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign o_done      = i_waiting && i_mem_ready;
    assign o_timed_out = i_waiting && !i_mem_ready && (r_wait_cnt == LAST);

endmodule

// File: rtl/mips_stage_responder.sv
// Executes one stage command at a time: strobes 1 cycle after sampling, ack 1 cycle later (plus memory wait).
// Commands arriving while busy are dropped; all outputs come straight from flops.
module mips_stage_responder
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    mips_stage_responder_if.slave  bus
);
    rsp_state_t       r_state, w_state_nxt;
    logic [2:0]       r_code, w_code_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_err, w_err_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_ir_we, w_ir_we_nxt;
    logic             r_pc_we, w_pc_we_nxt;
    logic             r_reg_rd, w_reg_rd_nxt;
    logic             r_alu_en, w_alu_en_nxt;
    logic             r_mem_req, w_mem_req_nxt;
    logic             r_mem_we, w_mem_we_nxt;
    logic             r_reg_we, w_reg_we_nxt;
    logic [CNT_W-1:0] r_retired, w_retired_nxt;
    logic             w_waiting, w_done, w_timed_out;
    logic             w_is_ls, w_no_wb;

    assign w_waiting = (r_state == ST_MEM_WAIT);
    assign w_is_ls   = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    assign w_no_wb   = (bus.opcode == OP_SW) || (bus.opcode == OP_BEQ) || (bus.opcode == OP_J);

    mips_mem_handshake #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_hs (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_waiting   (w_waiting),
        .i_mem_ready (bus.mem_ready),
        .o_done      (w_done),
        .o_timed_out (w_timed_out)
    );

    // Output flops are loaded with the values for the state being entered,
    // so every strobe lines up with its state without an input-to-output path.
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_ack_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_busy_nxt    = 1'b1;
        w_ir_we_nxt   = 1'b0;
        w_pc_we_nxt   = 1'b0;
        w_reg_rd_nxt  = 1'b0;
        w_alu_en_nxt  = 1'b0;
        w_mem_req_nxt = 1'b0;
        w_mem_we_nxt  = 1'b0;
        w_reg_we_nxt  = 1'b0;
        w_retired_nxt = r_retired;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = bus.stage_valid;
                if (bus.stage_valid) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_code_nxt    = bus.stage_code;
                    w_ir_we_nxt   = (bus.stage_code == STAGE_FETCH);
                    w_pc_we_nxt   = (bus.stage_code == STAGE_FETCH);
                    w_reg_rd_nxt  = (bus.stage_code == STAGE_DECODE);
                    w_alu_en_nxt  = (bus.stage_code == STAGE_EXECUTE);
                    w_mem_req_nxt = (bus.stage_code == STAGE_FETCH) ||
                                    ((bus.stage_code == STAGE_MEMORY) && w_is_ls);
                    w_mem_we_nxt  = (bus.stage_code == STAGE_MEMORY) && (bus.opcode == OP_SW);
                    w_reg_we_nxt  = (bus.stage_code == STAGE_WRITEBACK) && !w_no_wb;
                end
            end
            ST_ACTIVE: begin
                if (r_mem_req) begin
                    w_state_nxt   = ST_MEM_WAIT;
                    w_mem_req_nxt = 1'b1;
                    w_mem_we_nxt  = r_mem_we;
                end else begin
                    w_state_nxt = ST_ACK;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = !is_legal_stage(r_code);
                end
            end
            ST_MEM_WAIT: begin
                if (w_done || w_timed_out) begin
                    w_state_nxt = ST_ACK;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = w_timed_out;
                end else begin
                    w_mem_req_nxt = 1'b1;
                    w_mem_we_nxt  = r_mem_we;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                if ((r_code == STAGE_WRITEBACK) && !r_err) begin
                    w_retired_nxt = r_retired + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_code    <= STAGE_FETCH;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_ir_we   <= 1'b0;
            r_pc_we   <= 1'b0;
            r_reg_rd  <= 1'b0;
            r_alu_en  <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_reg_we  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_code    <= w_code_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_ir_we   <= w_ir_we_nxt;
            r_pc_we   <= w_pc_we_nxt;
            r_reg_rd  <= w_reg_rd_nxt;
            r_alu_en  <= w_alu_en_nxt;
            r_mem_req <= w_mem_req_nxt;
            r_mem_we  <= w_mem_we_nxt;
            r_reg_we  <= w_reg_we_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    assign bus.stage_ack     = r_ack;
    assign bus.stage_err     = r_err;
    assign bus.busy          = r_busy;
    assign bus.ir_we         = r_ir_we;
    assign bus.pc_we         = r_pc_we;
    assign bus.reg_rd        = r_reg_rd;
    assign bus.alu_en        = r_alu_en;
    assign bus.mem_req       = r_mem_req;
    assign bus.mem_we        = r_mem_we;
    assign bus.reg_we        = r_reg_we;
    assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_mips_stage_responder.sv
// Scoreboard bench for mips_stage_responder: a command-level model predicts each acknowledge,
// and an independent monitor matches what the DUT presents per command.
module tb_mips_stage_responder;
    localparam int MEM_TO   = 15;
    localparam int CNT_W_TB = 4;   // narrow counter so wrap from all-ones is reached
    localparam int RET_MOD  = 1 << CNT_W_TB;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] JMP = 6'h02;

    typedef struct {
        int err; int ir; int pc; int rd; int alu; int rwe; int mreq; int mwe; int busy; int ret;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks  = 0;
    int   n_err     = 0;
    int   model_ret = 0;
    exp_t sb[$];
    int   a_ir, a_pc, a_rd, a_alu, a_rwe, a_mreq, a_mwe, a_busy;
    bit   ret_pend;
    int   ret_exp;

    mips_stage_responder_if #(.CNT_W(CNT_W_TB)) bus ();

    mips_stage_responder #(
        .MEM_TIMEOUT (MEM_TO),
        .CNT_W       (CNT_W_TB)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({bus.stage_ack, bus.stage_err, bus.busy, bus.ir_we, bus.pc_we,
                     bus.reg_rd, bus.alu_en, bus.mem_req, bus.mem_we, bus.reg_we});
    endfunction

    function automatic void clear_acc();
        a_ir = 0; a_pc = 0; a_rd = 0; a_alu = 0; a_rwe = 0; a_mreq = 0; a_mwe = 0; a_busy = 0;
    endfunction

    // Monitor: accumulates per-command activity and compares at each acknowledge.
    always @(negedge clk) begin
        if (!rst_n) begin
            clear_acc();
            ret_pend = 1'b0;
        end else begin
            if (ret_pend) begin
                check("retired_count", int'(bus.retired_count), ret_exp);
                ret_pend = 1'b0;
            end
            if (!bus.busy) begin
                check("idle_outputs_quiet", outs(), 0);
            end else begin
                a_busy++;
                a_ir   += int'(bus.ir_we);
                a_pc   += int'(bus.pc_we);
                a_rd   += int'(bus.reg_rd);
                a_alu  += int'(bus.alu_en);
                a_rwe  += int'(bus.reg_we);
                a_mreq += int'(bus.mem_req);
                a_mwe  += int'(bus.mem_we);
                if (!bus.stage_ack) begin
                    check("err_without_ack", int'(bus.stage_err), 0);
                end else begin
                    check("ack_expected", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("stage_err",     int'(bus.stage_err), e.err);
                        check("ir_we_cycles",  a_ir,   e.ir);
                        check("pc_we_cycles",  a_pc,   e.pc);
                        check("reg_rd_cycles", a_rd,   e.rd);
                        check("alu_en_cycles", a_alu,  e.alu);
                        check("reg_we_cycles", a_rwe,  e.rwe);
                        check("mem_req_cycles", a_mreq, e.mreq);
                        check("mem_we_cycles", a_mwe,  e.mwe);
                        check("busy_cycles",   a_busy, e.busy);
                        ret_exp  = e.ret;
                        ret_pend = 1'b1;
                    end
                    clear_acc();
                end
            end
        end
    end

    task automatic noise_inputs(input bit noise);
        bus.stage_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.stage_code  = 3'($urandom_range(0, 7));
        bus.opcode      = 6'($urandom_range(0, 63));
        bus.mem_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    // d = wait cycle (0-based) on which memory answers; d >= MEM_TO means never.
    task automatic issue(input logic [2:0] code, input logic [5:0] op, input int d, input bit noise);
        exp_t e;
        bit   mem_st;
        int   w;
        mem_st  = (code == 3'd0) || ((code == 3'd3) && (op == LW || op == SW));
        w       = !mem_st ? 0 : ((d < MEM_TO) ? d + 1 : MEM_TO);
        e.err   = ((code == 3'd5) || (code == 3'd7) || (mem_st && d >= MEM_TO)) ? 1 : 0;
        e.ir    = (code == 3'd0) ? 1 : 0;
        e.pc    = (code == 3'd0) ? 1 : 0;
        e.rd    = (code == 3'd1) ? 1 : 0;
        e.alu   = (code == 3'd2) ? 1 : 0;
        e.rwe   = ((code == 3'd4) && !(op == SW || op == BEQ || op == JMP)) ? 1 : 0;
        e.mreq  = mem_st ? 1 + w : 0;
        e.mwe   = ((code == 3'd3) && (op == SW)) ? 1 + w : 0;
        e.busy  = 2 + w;
        if ((code == 3'd4) && (e.err == 0)) model_ret = (model_ret + 1) % RET_MOD;
        e.ret   = model_ret;
        sb.push_back(e);

        bus.stage_valid = 1'b1;
        bus.stage_code  = code;
        bus.opcode      = op;
        bus.mem_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        noise_inputs(noise);
        if (mem_st) begin
            @(posedge clk); #1;
            for (int i = 0; i < MEM_TO; i++) begin
                noise_inputs(noise);
                bus.mem_ready = (i == d);
                @(posedge clk); #1;
                if (i == d) break;
            end
        end else begin
            @(posedge clk); #1;
        end
        noise_inputs(noise);
        @(posedge clk); #1;
        bus.stage_valid = 1'b0;
        bus.mem_ready   = 1'b0;
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return LW;
            1:       return SW;
            2:       return BEQ;
            3:       return JMP;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        rst_n           = 1'b0;
        bus.stage_valid = 1'b0;
        bus.stage_code  = 3'd0;
        bus.opcode      = 6'd0;
        bus.mem_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        check("reset_retired", int'(bus.retired_count), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch left hanging in MEM_WAIT, then reset lands in cycle 3.
        bus.stage_valid = 1'b1;
        bus.stage_code  = 3'd0;
        bus.opcode      = LW;
        @(posedge clk); #1;
        bus.stage_valid = 1'b0;
        check("fetch_active_ir_we", int'(bus.ir_we), 1);
        check("fetch_active_mem_req", int'(bus.mem_req), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("fetch_wait_busy", int'(bus.busy), 1);
        check("fetch_wait_mem_req", int'(bus.mem_req), 1);
        check("fetch_wait_ir_we", int'(bus.ir_we), 0);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_abort_idle", int'(bus.busy), 0);
        model_ret = 0;

        issue(3'd1, pick_op(), 0, 1'b0);          // decode
        issue(3'd3, SW, 4, 1'b0);                 // store, ready on 5th wait cycle
        issue(3'd3, LW, 1000, 1'b0);              // load timeout
        issue(3'd3, LW, MEM_TO - 1, 1'b0);        // ready exactly on the timeout cycle
        issue(3'd3, BEQ, 0, 1'b0);                // memory stage without access
        repeat (3) for (int c = 0; c <= 4; c++) issue(3'(c), LW, $urandom_range(0, 3), 1'b0);
        repeat (3) for (int c = 0; c <= 4; c++) issue(3'(c), BEQ, $urandom_range(0, 3), 1'b0);
        issue(3'd5, pick_op(), 0, 1'b1);          // illegal with busy-time strobes
        issue(3'd7, pick_op(), 0, 1'b1);
        issue(3'd6, pick_op(), 0, 1'b1);          // extra
        issue(3'd4, SW, 0, 1'b0);
        issue(3'd4, JMP, 0, 1'b0);
        repeat (RET_MOD + 2) issue(3'd4, LW, 0, 1'b1);

        repeat (150) begin
            issue(3'($urandom_range(0, 7)), pick_op(), $urandom_range(0, 18), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                bus.mem_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            bus.mem_ready = 1'b0;
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_stage_responder.md
Name: mips_stage_responder

Overview:
- Datapath-side responder to the multicycle MIPS stage sequencer.
- Accepts one stage command at a time. Each command carries a 3-bit stage code and a valid strobe.
- For each command it decodes one-cycle datapath strobes, runs the memory request/ready handshake for memory-using stages, and returns a one-cycle stage acknowledge (with an error flag) to the sequencer.
- Counts retired instructions on each completed writeback.

Parameters:
- MEM_TIMEOUT, 15: max cycles spent in MEM_WAIT before aborting with error.
- CNT_W, 32: width of retired_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stage_code  in  3  stage command: 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback, 6 extra; 5 and 7 are illegal.
- stage_valid  in  1  command strobe, sampled only in IDLE.
- opcode  in  6  current instruction opcode, sampled with the command.
- mem_ready  in  1  memory completion, sampled only in MEM_WAIT.
- stage_ack  out  1  one-cycle pulse: stage finished.
- stage_err  out  1  valid with stage_ack: illegal code or memory timeout.
- busy  out  1  high in every state except IDLE.
- ir_we  out  1  instruction-register load strobe (fetch).
- pc_we  out  1  PC update strobe (fetch).
- reg_rd  out  1  register-file read strobe (decode).
- alu_en  out  1  ALU operate strobe (execute).
- mem_req  out  1  memory request, held through the handshake.
- mem_we  out  1  memory write qualifier, valid while mem_req is high.
- reg_we  out  1  register-file write strobe (writeback).
- retired_count  out  CNT_W  number of completed writebacks.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; retired_count=0; timeout counter=0. Assertion mid-operation aborts immediately. No ack is issued for an aborted command.
- States: IDLE, ACTIVE, MEM_WAIT, ACK.
- IDLE:
  - On stage_valid=1, latch stage_code and opcode, then go to ACTIVE.
  - stage_valid in any other state is ignored; no queueing.
- ACTIVE (exactly one cycle): assert the strobe for the latched stage.
  - Fetch: ir_we=1, pc_we=1, mem_req=1, mem_we=0. Next state MEM_WAIT.
  - Decode: reg_rd=1. Next state ACK.
  - Execute: alu_en=1. Next state ACK.
  - Memory with lw (0x23): mem_req=1, mem_we=0. Next state MEM_WAIT.
  - Memory with sw (0x2B): mem_req=1, mem_we=1. Next state MEM_WAIT.
  - Memory with any other opcode: no strobe. Next state ACK.
  - Writeback: reg_we=1 unless opcode is sw (0x2B), beq (0x04) or j (0x02). Next state ACK.
  - Extra (6): no strobe. Next state ACK.
  - Illegal (5, 7): no strobe. Set err flag, next state ACK.
- MEM_WAIT:
  - mem_req and mem_we hold their ACTIVE values.
  - The timeout counter starts at 0 on entry and increments each cycle.
  - If mem_ready=1, go to ACK with err=0. mem_req drops in the ACK cycle.
  - If the counter reaches MEM_TIMEOUT-1 with mem_ready=0, go to ACK with err=1.
  - mem_ready=1 on the timeout cycle takes priority: success.
- ACK (one cycle): stage_ack=1, stage_err=err. Next state IDLE, err cleared.
  - Writeback without error: retired_count increments on the same edge that leaves ACK.
  - retired_count wraps from all-ones to 0 silently.
- Latency, command sampled in IDLE at cycle 0:
  - Non-memory stage: strobe in cycle 1, ack in cycle 2.
  - Memory stage with mem_ready already high: strobe in cycle 1, ready sampled in cycle 2, ack in cycle 3.
  - A back-to-back command can be sampled in the cycle after ack, so the minimum stage period is 3 cycles.
- mem_ready outside MEM_WAIT is ignored.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package mips_pkg holds:
  - Stage code constants: STAGE_FETCH=0, STAGE_DECODE=1, STAGE_EXECUTE=2, STAGE_MEMORY=3, STAGE_WRITEBACK=4, STAGE_EXTRA=6. The sequencer and this block must share these.
  - Opcode constants: OP_LW=0x23, OP_SW=0x2B, OP_BEQ=0x04, OP_J=0x02.
  - Responder state enum.
- One sub-module: mips_mem_handshake, containing the MEM_WAIT timeout counter and the ready/timeout decision. It outputs done and timed_out to the main FSM.

Test Plan:
- Reset mid MEM_WAIT: fetch command, mem_ready=0, then reset_n=0 at cycle 3 -> all outputs 0 immediately; no stage_ack; IDLE after release.
- Decode command (code 1) at cycle 0 -> reg_rd=1 at cycle 1 only; stage_ack=1, stage_err=0 at cycle 2; busy=1 for cycles 1-2.
- Memory stage, opcode 0x2B, mem_ready asserted 4 cycles after MEM_WAIT entry -> mem_req=1 and mem_we=1 continuously from ACTIVE through the ready cycle; ack 1 cycle later with err=0.
- Memory stage, opcode 0x23, mem_ready never asserted, MEM_TIMEOUT=15 -> mem_req high for 1+15 cycles; stage_ack=1, stage_err=1; retired_count unchanged.
- Full sequence 0,1,2,3,4 with opcode 0x23 repeated 3 times -> retired_count=3; reg_we pulsed 3 times. Repeat with opcode 0x04 -> reg_we never asserted; count still increments.
- Illegal code 5, plus stage_valid pulsed while busy -> ack with err=1 at cycle 2; the busy-time pulse produces no extra ack; retired_count wraps from 0xFFFFFFFF to 0 after a forced preload.
